trigger_ctrl: RTL and testbench

TRIGGER_CTRL -- requirements
Module: trigger_ctrl

---
 rtl/trigger_ctrl.sv | 172 +++++++++++++++++
 tb/tb_trigger_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// Debug trigger CSR block: tselect/tdata1/tdata2 storage, breakpoint
// unit configuration and a single-entry trap request FSM.
module trigger_ctrl #(
  parameter int NTRIG = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  io_status_debug,
  input  logic                  io_csr_wen,
  input  logic [11:0]           io_csr_addr,
  input  logic [31:0]           io_csr_wdata,
  output logic [31:0]           io_csr_rdata,
  output logic [9*NTRIG-1:0]    io_bp_control,
  output logic [32*NTRIG-1:0]   io_bp_address,
  input  logic [NTRIG-1:0]      io_hit_if,
  input  logic [NTRIG-1:0]      io_hit_ld,
  input  logic [NTRIG-1:0]      io_hit_st,
  output logic                  io_trap_valid,
  input  logic                  io_trap_ready,
  output logic                  io_trap_debug,
  output logic [1:0]            io_trap_index,
  output logic [1:0]            io_trap_kind,
  input  logic                  io_flush
);

  localparam logic [11:0] A_TSEL = 12'h7A0;
  localparam logic [11:0] A_TD1  = 12'h7A1;
  localparam logic [11:0] A_TD2  = 12'h7A2;

  typedef struct packed {
    logic        dmode;
    logic        action;
    logic [1:0]  tmatch;
    logic        m;
    logic        s;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        hit;
    logic [31:0] addr;
  } trig_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_WAIT
  } state_t;

  // Sized for the max trigger count so tselect indexes without truncation
  trig_t  trig_q [4];
  logic [1:0] tsel_q;
  state_t state_q;

  function automatic logic [31:0] tdata1_of(trig_t t);
    logic [31:0] v;
    v = '0;
    v[31:28] = 4'd2;
    v[27]    = t.dmode;
    v[20]    = t.hit;
    v[12]    = t.action;
    v[8:7]   = t.tmatch;
    v[6]     = t.m;
    v[4]     = t.s;
    v[3]     = t.u;
    v[2]     = t.x;
    v[1]     = t.w;
    v[0]     = t.r;
    return v;
  endfunction

  trig_t cur;
  assign cur = trig_q[tsel_q];

  always_comb begin
    io_csr_rdata = '0;
    unique case (io_csr_addr)
      A_TSEL:  io_csr_rdata = {30'd0, tsel_q};
      A_TD1:   io_csr_rdata = tdata1_of(cur);
      A_TD2:   io_csr_rdata = cur.addr;
      default: io_csr_rdata = '0;
    endcase
  end

  logic wr_tsel, wr_td1, wr_td2, locked;
  logic new_dmode;
  logic [1:0] new_tmatch;

  assign wr_tsel = io_csr_wen && (io_csr_addr == A_TSEL);
  assign wr_td1  = io_csr_wen && (io_csr_addr == A_TD1);
  assign wr_td2  = io_csr_wen && (io_csr_addr == A_TD2);
  assign locked  = cur.dmode && !io_status_debug;
  assign new_dmode  = io_status_debug && io_csr_wdata[27];
  assign new_tmatch = (io_csr_wdata[10:7] > 4'd3)
                    ? 2'd0 : io_csr_wdata[8:7];

  // Descending scan so the lowest-index hitting trigger wins
  logic       cap;
  logic [1:0] cap_idx;
  logic [1:0] cap_kind;

  always_comb begin
    cap      = 1'b0;
    cap_idx  = 2'd0;
    cap_kind = 2'd0;
    for (int i = NTRIG - 1; i >= 0; i--) begin
      if (io_hit_if[i] || io_hit_ld[i] || io_hit_st[i]) begin
        cap     = 1'b1;
        cap_idx = 2'(i);
        if (io_hit_if[i])      cap_kind = 2'd0;
        else if (io_hit_ld[i]) cap_kind = 2'd1;
        else                   cap_kind = 2'd2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) trig_q[i] <= '0;
      tsel_q        <= 2'd0;
      state_q       <= S_IDLE;
      io_trap_valid <= 1'b0;
      io_trap_debug <= 1'b0;
      io_trap_index <= 2'd0;
      io_trap_kind  <= 2'd0;
    end else begin
      if (wr_tsel && io_csr_wdata < 32'(NTRIG))
        tsel_q <= io_csr_wdata[1:0];
      if (wr_td1 && !locked) begin
        trig_q[tsel_q].dmode  <= new_dmode;
        trig_q[tsel_q].action <= io_csr_wdata[12] && new_dmode;
        trig_q[tsel_q].tmatch <= new_tmatch;
        trig_q[tsel_q].m      <= io_csr_wdata[6];
        trig_q[tsel_q].s      <= io_csr_wdata[4];
        trig_q[tsel_q].u      <= io_csr_wdata[3];
        trig_q[tsel_q].x      <= io_csr_wdata[2];
        trig_q[tsel_q].w      <= io_csr_wdata[1];
        trig_q[tsel_q].r      <= io_csr_wdata[0];
        trig_q[tsel_q].hit    <= io_csr_wdata[20];
      end
      if (wr_td2 && !locked)
        trig_q[tsel_q].addr <= io_csr_wdata;
      // Capture comes last so its hit set beats a CSR clear
      unique case (state_q)
        S_IDLE: if (cap) begin
          trig_q[cap_idx].hit <= 1'b1;
          io_trap_index <= cap_idx;
          io_trap_kind  <= cap_kind;
          io_trap_debug <= trig_q[cap_idx].action;
          io_trap_valid <= 1'b1;
          state_q       <= S_PEND;
        end
        S_PEND: if (io_trap_ready) begin
          io_trap_valid <= 1'b0;
          state_q       <= S_WAIT;
        end
        S_WAIT: if (io_flush) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NTRIG; g++) begin : g_out
    assign io_bp_control[9*g +: 9] = {
      trig_q[g].action, trig_q[g].tmatch,
      trig_q[g].m, trig_q[g].s, trig_q[g].u,
      trig_q[g].x, trig_q[g].w, trig_q[g].r
    };
    assign io_bp_address[32*g +: 32] = trig_q[g].addr;
  end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl: CSR behaviour, capture FSM
// and reset, with expectations queued and popped per sample.
module tb_trigger_ctrl;
  localparam int NTRIG = 2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic io_status_debug = 1'b0;
  logic io_csr_wen = 1'b0;
  logic [11:0] io_csr_addr = '0;
  logic [31:0] io_csr_wdata = '0;
  logic [31:0] io_csr_rdata;
  logic [9*NTRIG-1:0] io_bp_control;
  logic [32*NTRIG-1:0] io_bp_address;
  logic [NTRIG-1:0] io_hit_if = '0;
  logic [NTRIG-1:0] io_hit_ld = '0;
  logic [NTRIG-1:0] io_hit_st = '0;
  logic io_trap_valid;
  logic io_trap_ready = 1'b0;
  logic io_trap_debug;
  logic [1:0] io_trap_index;
  logic [1:0] io_trap_kind;
  logic io_flush = 1'b0;

  logic [63:0] exp_q [$];
  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  trigger_ctrl #(.NTRIG(NTRIG)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .io_status_debug(io_status_debug),
    .io_csr_wen(io_csr_wen),
    .io_csr_addr(io_csr_addr),
    .io_csr_wdata(io_csr_wdata),
    .io_csr_rdata(io_csr_rdata),
    .io_bp_control(io_bp_control),
    .io_bp_address(io_bp_address),
    .io_hit_if(io_hit_if),
    .io_hit_ld(io_hit_ld),
    .io_hit_st(io_hit_st),
    .io_trap_valid(io_trap_valid),
    .io_trap_ready(io_trap_ready),
    .io_trap_debug(io_trap_debug),
    .io_trap_index(io_trap_index),
    .io_trap_kind(io_trap_kind),
    .io_flush(io_flush)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected none queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    io_csr_addr  = a;
    io_csr_wdata = d;
    io_csr_wen   = 1'b1;
    tick();
    io_csr_wen   = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    io_csr_addr = a;
    #1;
    v = io_csr_rdata;
  endtask

  function automatic logic [63:0] trap();
    return 64'({io_trap_valid, io_trap_debug,
                io_trap_index, io_trap_kind});
  endfunction

  logic [31:0] v;

  initial begin
    // reset
    tick(); tick();
    reset_n = 1'b1;
    push(64'h0);        chk("rst_ctrl", 64'(io_bp_control));
    push(64'h0);        chk("rst_addr", io_bp_address);
    push(64'h0);        chk("rst_trap", trap());
    push(64'h20000000); rd(12'h7A1, v); chk("rst_td1", 64'(v));

    // trigger1: action forced 0 outside debug
    csr_wr(12'h7A0, 32'd1);
    csr_wr(12'h7A1, 32'h0000_1084);
    push(64'h08800);    chk("ctrl1", 64'(io_bp_control));
    push(64'h20000084); rd(12'h7A1, v); chk("td1_t1", 64'(v));
    push(64'd1);        rd(12'h7A0, v); chk("tsel1", 64'(v));
    csr_wr(12'h7A2, 32'h1234_5678);
    push(64'h12345678_00000000);
    chk("addr1", io_bp_address);

    // match field above 3 stores 0
    csr_wr(12'h7A1, 32'h0000_0201);
    push(64'h00200);    chk("tmatch_big", 64'(io_bp_control));
    push(64'h20000001); rd(12'h7A1, v); chk("td1_big", 64'(v));

    // out-of-range tselect
    csr_wr(12'h7A0, 32'd5);
    push(64'd1); rd(12'h7A0, v); chk("tsel_5", 64'(v));
    csr_wr(12'h7A0, 32'd2);
    push(64'd1); rd(12'h7A0, v); chk("tsel_2", 64'(v));
    csr_wr(12'h7A0, 32'd0);
    push(64'd0); rd(12'h7A0, v); chk("tsel_0", 64'(v));

    // capture: trigger0 ld beats trigger1 if
    io_hit_ld = 2'b11;
    io_hit_if = 2'b10;
    push(64'h21);
    tick();
    io_hit_ld = 2'b00;
    io_hit_if = 2'b00;
    chk("cap_ld", trap());
    io_hit_if = 2'b10;
    for (int i = 0; i < 3; i++) begin
      push(64'h21);
      tick();
      chk("pend_hold", trap());
    end
    io_hit_if = 2'b00;
    io_trap_ready = 1'b1;
    push(64'h01);
    tick();
    io_trap_ready = 1'b0;
    chk("to_wait", trap());
    io_hit_st = 2'b01;
    push(64'h01);
    tick();
    chk("wait_ign", trap());
    io_hit_st = 2'b00;
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    push(64'h01);
    tick();
    chk("idle_quiet", trap());
    push(64'h20100000); rd(12'h7A1, v); chk("hit0", 64'(v));
    csr_wr(12'h7A0, 32'd1);
    push(64'h20000001); rd(12'h7A1, v); chk("hit1_clr", 64'(v));

    // capture beats simultaneous hit-bit clear
    io_hit_if = 2'b10;
    push(64'h24);
    csr_wr(12'h7A1, 32'h0);
    io_hit_if = 2'b00;
    chk("cap_if1", trap());
    push(64'h20100000); rd(12'h7A1, v); chk("hit_race", 64'(v));
    io_trap_ready = 1'b1;
    tick();
    io_trap_ready = 1'b0;
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;

    // trigger0 clear, then dmode lock
    csr_wr(12'h7A0, 32'd0);
    csr_wr(12'h7A1, 32'h0);
    push(64'h20000000); rd(12'h7A1, v); chk("hit0_clr", 64'(v));
    io_status_debug = 1'b1;
    csr_wr(12'h7A1, 32'h0800_1004);
    csr_wr(12'h7A2, 32'hAAAA_0000);
    io_status_debug = 1'b0;
    push(64'h28001004); rd(12'h7A1, v); chk("dmode_set", 64'(v));
    csr_wr(12'h7A1, 32'h0);
    csr_wr(12'h7A2, 32'h55);
    push(64'h28001004); rd(12'h7A1, v); chk("dmode_lock", 64'(v));
    push(64'h12345678_AAAA0000);
    chk("addr_lock", io_bp_address);
    push(64'h00104);    chk("ctrl_dbg", 64'(io_bp_control));

    // debug-entry trap, then config change while pending
    io_hit_st = 2'b01;
    push(64'h32);
    tick();
    io_hit_st = 2'b00;
    chk("cap_dbg", trap());
    io_status_debug = 1'b1;
    push(64'h32);
    csr_wr(12'h7A1, 32'h0);
    io_status_debug = 1'b0;
    chk("pend_cfg", trap());

    // reset in PEND overrides CSR write and hit
    reset_n = 1'b0;
    io_hit_if = 2'b01;
    push(64'h0);
    csr_wr(12'h7A0, 32'd1);
    io_hit_if = 2'b00;
    chk("rst_pend", trap());
    push(64'h0); chk("rst2_ctrl", 64'(io_bp_control));
    push(64'h0); chk("rst2_addr", io_bp_address);
    reset_n = 1'b1;
    push(64'd0);        rd(12'h7A0, v); chk("rst2_tsel", 64'(v));
    push(64'h20000000); rd(12'h7A1, v); chk("rst2_td1", 64'(v));
    push(64'h0);
    tick();
    chk("rst2_idle", trap());

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
